// File: rtl/beam_guard_mc.sv
// Multi-channel beam guard: per-channel sync + PRE/ARMED/BEAM/POST/FIRE qualifier.
// Optional BEAM_GUARD_EVTCNT_EN adds per-channel saturating FIRE-entry counters.
module beam_guard_ch #(
  parameter int CNT_W       = 8,
  parameter int PW_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             beam_i,
  input  logic [CNT_W-1:0] cfg_pre,
  input  logic [CNT_W-1:0] cfg_post,
  input  logic [CNT_W-1:0] cfg_max_beam,
  input  logic [PW_W-1:0]  cfg_width,
  input  logic             err_clr_i,
`ifdef BEAM_GUARD_EVTCNT_EN
  input  logic             evt_clr_i,
  output logic [15:0]      evt_cnt_o,
`endif
  output logic             trig_o,
  output logic             busy_o,
  output logic             err_o
);
  typedef enum logic [2:0] {S_PRE, S_ARMED, S_BEAM, S_POST, S_FIRE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, eff_pre, eff_post, cnt_sat;
  logic [PW_W-1:0]        pw_q, pw_d, eff_w;
  logic [CNT_W:0]         cnt_inc;
  logic [PW_W:0]          pw_inc;
  logic                   beam_s, err_q, err_set, fire_ent;

  assign beam_s   = sync_q[SYNC_STAGES-1];
  assign eff_pre  = (cfg_pre   == '0) ? CNT_W'(1) : cfg_pre;
  assign eff_post = (cfg_post  == '0) ? CNT_W'(1) : cfg_post;
  assign eff_w    = (cfg_width == '0) ? PW_W'(1)  : cfg_width;
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_sat  = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
  assign pw_inc   = {1'b0, pw_q} + (PW_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    err_set  = 1'b0;
    fire_ent = 1'b0;
    if (!enable) begin
      state_d = S_PRE;
      cnt_d   = '0;
      pw_d    = '0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (beam_s) cnt_d = '0;
          // >= so a shrinking cfg_pre mid-window still arms instead of stalling
          else if (cnt_inc >= {1'b0, eff_pre}) begin
            state_d = S_ARMED;
            cnt_d   = eff_pre;
          end else cnt_d = cnt_inc[CNT_W-1:0];
        end
        S_ARMED: begin
          if (beam_s) begin
            state_d = S_BEAM;
            cnt_d   = CNT_W'(1);
          end
        end
        S_BEAM: begin
          if (beam_s) begin
            if (cfg_max_beam != '0 && cnt_inc > {1'b0, cfg_max_beam}) begin
              err_set = 1'b1;
              state_d = S_PRE;
              cnt_d   = '0;
            end else cnt_d = cnt_sat;
          end else begin
            state_d = S_POST;
            cnt_d   = CNT_W'(1);
          end
        end
        S_POST: begin
          if (beam_s) begin
            state_d = S_PRE;
            cnt_d   = '0;
          end else if (cnt_q >= eff_post) begin
            state_d  = S_FIRE;
            cnt_d    = '0;
            pw_d     = '0;
            fire_ent = 1'b1;
          end else cnt_d = cnt_inc[CNT_W-1:0];
        end
        S_FIRE: begin
          if (pw_inc >= {1'b0, eff_w}) begin
            state_d = S_PRE;
            cnt_d   = '0;
            pw_d    = '0;
          end else pw_d = pw_inc[PW_W-1:0];
        end
        default: begin
          state_d = S_PRE;
          cnt_d   = '0;
          pw_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_PRE;
      sync_q  <= '0;
      cnt_q   <= '0;
      pw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], beam_i};
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      err_q   <= err_set | (err_q & ~err_clr_i);
    end
  end

`ifdef BEAM_GUARD_EVTCNT_EN
  logic [15:0] evt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          evt_q <= '0;
    else if (evt_clr_i)                  evt_q <= '0;
    else if (fire_ent && evt_q != '1)    evt_q <= evt_q + 16'd1;
  end
  assign evt_cnt_o = evt_q;
`endif

  assign trig_o = (state_q == S_FIRE);
  assign busy_o = (state_q == S_BEAM) || (state_q == S_POST) || (state_q == S_FIRE);
  assign err_o  = err_q;
endmodule

module beam_guard_mc #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int PW_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   i_beam,
  input  logic [CNT_W-1:0]  cfg_pre,
  input  logic [CNT_W-1:0]  cfg_post,
  input  logic [CNT_W-1:0]  cfg_max_beam,
  input  logic [PW_W-1:0]   cfg_width,
  input  logic              err_clr,
`ifdef BEAM_GUARD_EVTCNT_EN
  input  logic              evt_clr,
  output logic [N_CH*16-1:0] evt_cnt,
`endif
  output logic [N_CH-1:0]   trig_out,
  output logic              trig_any,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   err_long
);
  logic trig_any_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    beam_guard_ch #(.CNT_W(CNT_W), .PW_W(PW_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .beam_i       (i_beam[c]),
      .cfg_pre      (cfg_pre),
      .cfg_post     (cfg_post),
      .cfg_max_beam (cfg_max_beam),
      .cfg_width    (cfg_width),
      .err_clr_i    (err_clr),
`ifdef BEAM_GUARD_EVTCNT_EN
      .evt_clr_i    (evt_clr),
      .evt_cnt_o    (evt_cnt[c*16 +: 16]),
`endif
      .trig_o       (trig_out[c]),
      .busy_o       (busy[c]),
      .err_o        (err_long[c])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trig_any_q <= 1'b0;
    else        trig_any_q <= |trig_out;
  end
  assign trig_any = trig_any_q;
endmodule

// File: tb/tb_beam_guard_mc.sv
// Directed bench for beam_guard_mc: N_CH=2, pre=4, post=3, width=2, max_beam=8.
module tb_beam_guard_mc;
  logic        clk = 1'b0;
  logic        reset, enable, err_clr;
  logic [1:0]  i_beam;
  logic [7:0]  cfg_pre, cfg_post, cfg_max_beam;
  logic [3:0]  cfg_width;
  logic [1:0]  trig_out, busy, err_long;
  logic        trig_any;
`ifdef BEAM_GUARD_EVTCNT_EN
  logic        evt_clr;
  logic [31:0] evt_cnt;
`endif

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int t0_cnt, t1_cnt, tboth_cnt, any_cnt, first0, first1, firstany, busy0_seen;
  int fall_edge;

  beam_guard_mc #(.N_CH(2), .CNT_W(8), .PW_W(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .i_beam       (i_beam),
    .cfg_pre      (cfg_pre),
    .cfg_post     (cfg_post),
    .cfg_max_beam (cfg_max_beam),
    .cfg_width    (cfg_width),
    .err_clr      (err_clr),
`ifdef BEAM_GUARD_EVTCNT_EN
    .evt_clr      (evt_clr),
    .evt_cnt      (evt_cnt),
`endif
    .trig_out     (trig_out),
    .trig_any     (trig_any),
    .busy         (busy),
    .err_long     (err_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle activity monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (trig_out[0]) begin t0_cnt++; if (first0 < 0) first0 = cyc; end
    if (trig_out[1]) begin t1_cnt++; if (first1 < 0) first1 = cyc; end
    if (trig_out == 2'b11) tboth_cnt++;
    if (trig_any) begin any_cnt++; if (firstany < 0) firstany = cyc; end
    if (busy[0]) busy0_seen++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    i_beam = v;
    step(n);
  endtask

  task automatic clr_mon();
    t0_cnt = 0; t1_cnt = 0; tboth_cnt = 0; any_cnt = 0; busy0_seen = 0;
    first0 = -1; first1 = -1; firstany = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0; i_beam = 2'b00; enable = 1'b1; err_clr = 1'b0;
`ifdef BEAM_GUARD_EVTCNT_EN
    evt_clr = 1'b0;
`endif
    step(2);
    reset = 1'b1;
    clr_mon();
  endtask

  task automatic wait_trig0();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (trig_out[0]) found = 1'b1;
      else step(1);
    end
    chk("wait_trig0", int'(found), 1);
  endtask

  task automatic normal_seq(input logic [1:0] v);
    drive(2'b00, 10);
    drive(v, 3);
    fall_edge = cyc + 1;
    i_beam = 2'b00;
  endtask

  initial begin
    cfg_pre = 8'd4; cfg_post = 8'd3; cfg_width = 4'd2; cfg_max_beam = 8'd8;
    clr_mon();
    do_reset();
    chk("rst_trig",  int'(trig_out), 0);
    chk("rst_any",   int'(trig_any), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_err",   int'(err_long), 0);

    // Normal fire on ch0 only
    normal_seq(2'b01);
    step(20);
    chk("norm_width",   t0_cnt, 2);
    chk("norm_latency", first0 - fall_edge, 5);
    chk("norm_any_lag", firstany - first0, 1);
    chk("norm_any_w",   any_cnt, 2);
    chk("norm_ch1",     t1_cnt, 0);

    // Only 3 quiet samples between highs: never arms
    do_reset();
    drive(2'b01, 4);
    drive(2'b00, 3);
    drive(2'b01, 2);
    drive(2'b00, 20);
    chk("shortpre_trig", t0_cnt, 0);
    chk("shortpre_busy", busy0_seen, 0);

    // Beam returns inside the post window, then a clean retry
    do_reset();
    drive(2'b00, 10);
    drive(2'b01, 3);
    drive(2'b00, 2);
    drive(2'b01, 1);
    drive(2'b00, 20);
    chk("postviol_trig", t0_cnt, 0);
    drive(2'b01, 3);
    fall_edge = cyc + 1;
    drive(2'b00, 20);
    chk("postviol_retry",   t0_cnt, 2);
    chk("postviol_latency", first0 - fall_edge, 5);

    // Overlong beam, clear, then clear coinciding with a new violation
    do_reset();
    drive(2'b00, 10);
    drive(2'b01, 12);
    chk("long_err",  int'(err_long[0]), 1);
    drive(2'b00, 20);
    chk("long_trig", t0_cnt, 0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("long_clr",  int'(err_long[0]), 0);
    drive(2'b01, 10);
    chk("long_pre_coincide", int'(err_long[0]), 0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("long_set_wins", int'(err_long[0]), 1);
    drive(2'b00, 10);

    // No beam-length limit: stays in BEAM, no error
    cfg_max_beam = 8'd0;
    do_reset();
    drive(2'b00, 10);
    drive(2'b01, 300);
    chk("nolimit_err",  int'(err_long[0]), 0);
    chk("nolimit_busy", int'(busy[0]), 1);
    chk("nolimit_trig", t0_cnt, 0);
    cfg_max_beam = 8'd8;

    // Reset asserted during the first trigger cycle
    do_reset();
    normal_seq(2'b01);
    wait_trig0();
    reset = 1'b0;
    #1;
    chk("rstfire_trig", int'(trig_out), 0);
    chk("rstfire_any",  int'(trig_any), 0);
    chk("rstfire_busy", int'(busy), 0);
    chk("rstfire_err",  int'(err_long), 0);
    step(1);
    reset = 1'b1;

    // Enable dropped during FIRE, then a fresh pre-window is needed
    do_reset();
    normal_seq(2'b01);
    wait_trig0();
    enable = 1'b0;
    step(1);
    chk("enfire_trig", int'(trig_out[0]), 0);
    chk("enfire_busy", int'(busy[0]), 0);
    enable = 1'b1;
    clr_mon();
    drive(2'b00, 1);
    drive(2'b01, 3);
    drive(2'b00, 20);
    chk("enfire_rearm_short", t0_cnt, 0);
    drive(2'b01, 3);
    drive(2'b00, 20);
    chk("enfire_rearm_ok", t0_cnt, 2);

    // Both channels in lockstep
    do_reset();
    normal_seq(2'b11);
    step(20);
    chk("par_ch0",   t0_cnt, 2);
    chk("par_ch1",   t1_cnt, 2);
    chk("par_both",  tboth_cnt, 2);
    chk("par_align", first1 - first0, 0);
`ifdef BEAM_GUARD_EVTCNT_EN
    chk("evt0_1", int'(evt_cnt[15:0]), 1);
    chk("evt1_1", int'(evt_cnt[31:16]), 1);
`endif
    normal_seq(2'b11);
    step(20);
    chk("par_both2", tboth_cnt, 4);
`ifdef BEAM_GUARD_EVTCNT_EN
    chk("evt0_2", int'(evt_cnt[15:0]), 2);
    chk("evt1_2", int'(evt_cnt[31:16]), 2);
    evt_clr = 1'b1; step(1); evt_clr = 1'b0;
    chk("evt_clr", int'(evt_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
